// File: rtl/io_port_endpoint_pkg.sv
// Shared definitions for the Octavo I/O port endpoint and its FIFOs.
// The EF polarity constants are also what the CPU I/O predication logic
// compares against, so both sides agree on what "ready" means.
package io_port_endpoint_pkg;

  // Empty/full flag polarity as seen by the CPU thread scheduler
  localparam logic IO_EF_READY   = 1'b1;
  localparam logic IO_EF_BLOCKED = 1'b0;

  // Default geometry of one port pair
  localparam int IO_WORD_WIDTH  = 36;
  localparam int IO_FIFO_DEPTH  = 8;
  localparam int IO_ADDR_WIDTH  = 3;
  localparam int IO_COUNT_WIDTH = IO_ADDR_WIDTH + 1;

  // FIFO operation for one cycle, encoded as {push, pop}
  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifoOpE;

endpackage

// File: rtl/io_port_fifo.sv
// Show-ahead FIFO with registered flags and a registered head word.
// Push and pop arrive already qualified by the caller against the flags.
// The head word is held when the FIFO drains, so the output never glitches
// or shows stale slots while empty.
module io_port_fifo
  import io_port_endpoint_pkg::*;
#(
  parameter int WORD_WIDTH  = IO_WORD_WIDTH,
  parameter int DEPTH       = IO_FIFO_DEPTH,
  parameter int ADDR_WIDTH  = IO_ADDR_WIDTH,
  parameter int COUNT_WIDTH = IO_COUNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_notEmpty,
  output logic                  o_notFull
);

  logic [WORD_WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_wrPtr;
  logic [ADDR_WIDTH-1:0]  r_rdPtr;
  logic [ADDR_WIDTH-1:0]  w_rdPtrInc;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_countNext;
  logic [WORD_WIDTH-1:0]  r_head;
  logic [WORD_WIDTH-1:0]  w_headNext;
  logic                   r_notEmpty;
  logic                   r_notFull;
  fifoOpE                 w_op;

  assign w_op       = fifoOpE'({i_push, i_pop});
  assign w_rdPtrInc = r_rdPtr + ADDR_WIDTH'(1);

  // Next occupancy and next head word; the head comes from the input word when
  // the FIFO is (or becomes) a single fresh entry, else from the slot behind it
  always_comb begin
    w_countNext = r_count;
    w_headNext  = r_head;
    case (w_op)
      FIFO_PUSH: begin
        w_countNext = r_count + COUNT_WIDTH'(1);
        if (r_count == '0) begin
          w_headNext = i_data;
        end
      end
      FIFO_POP: begin
        w_countNext = r_count - COUNT_WIDTH'(1);
        if (r_count != COUNT_WIDTH'(1)) begin
          w_headNext = r_mem[w_rdPtrInc];
        end
      end
      FIFO_BOTH: begin
        if (r_count == COUNT_WIDTH'(1)) begin
          w_headNext = i_data;
        end else begin
          w_headNext = r_mem[w_rdPtrInc];
        end
      end
      default: begin
        w_countNext = r_count;
      end
    endcase
  end

  // Pointers, count, head and flags; flags come from the next count so they
  // are valid at the start of every cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_notEmpty <= 1'b0;
      r_notFull  <= 1'b1;
    end else begin
      if (i_push) begin
        r_wrPtr <= r_wrPtr + ADDR_WIDTH'(1);
      end
      if (i_pop) begin
        r_rdPtr <= w_rdPtrInc;
      end
      r_count    <= w_countNext;
      r_head     <= w_headNext;
      r_notEmpty <= (w_countNext != '0);
      r_notFull  <= (w_countNext != COUNT_WIDTH'(DEPTH));
    end
  end

  // Storage array; contents need no reset because the pointers and head do
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  assign o_data     = r_head;
  assign o_notEmpty = r_notEmpty;
  assign o_notFull  = r_notFull;

endmodule

// File: rtl/io_port_endpoint.sv
// Device-side endpoint for one Octavo I/O port pair.
// The read FIFO is filled by an external producer and popped by the CPU;
// the write FIFO is filled by the CPU and drained by an external consumer.
// Strobes issued against a blocked EF are dropped and recorded in sticky flags.
module io_port_endpoint
  import io_port_endpoint_pkg::*;
#(
  parameter int WORD_WIDTH  = IO_WORD_WIDTH,
  parameter int FIFO_DEPTH  = IO_FIFO_DEPTH,
  parameter int ADDR_WIDTH  = IO_ADDR_WIDTH,
  parameter int COUNT_WIDTH = IO_COUNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  io_rden,
  output logic [WORD_WIDTH-1:0] io_read_data,
  output logic                  io_read_EF,
  input  logic                  io_wren,
  input  logic [WORD_WIDTH-1:0] io_write_data,
  output logic                  io_write_EF,
  input  logic                  ext_in_valid,
  output logic                  ext_in_ready,
  input  logic [WORD_WIDTH-1:0] ext_in_data,
  output logic                  ext_out_valid,
  input  logic                  ext_out_ready,
  output logic [WORD_WIDTH-1:0] ext_out_data,
  input  logic                  clear_errors,
  output logic                  rd_underrun,
  output logic                  wr_overrun
);

  logic w_rdPush;
  logic w_rdPop;
  logic w_rdNotEmpty;
  logic w_rdNotFull;
  logic w_wrPush;
  logic w_wrPop;
  logic w_wrNotEmpty;
  logic w_wrNotFull;
  logic w_rdUnderrunSet;
  logic w_wrOverrunSet;
  logic r_rdUnderrun;
  logic r_wrOverrun;

  assign io_read_EF    = w_rdNotEmpty ? IO_EF_READY : IO_EF_BLOCKED;
  assign io_write_EF   = w_wrNotFull  ? IO_EF_READY : IO_EF_BLOCKED;
  assign ext_in_ready  = w_rdNotFull;
  assign ext_out_valid = w_wrNotEmpty;

  assign w_rdPush = ext_in_valid && w_rdNotFull;
  assign w_rdPop  = io_rden && (io_read_EF == IO_EF_READY);
  assign w_wrPush = io_wren && (io_write_EF == IO_EF_READY);
  assign w_wrPop  = w_wrNotEmpty && ext_out_ready;

  assign w_rdUnderrunSet = io_rden && (io_read_EF == IO_EF_BLOCKED);
  assign w_wrOverrunSet  = io_wren && (io_write_EF == IO_EF_BLOCKED);

  io_port_fifo #(
    .WORD_WIDTH  (WORD_WIDTH),
    .DEPTH       (FIFO_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_readFifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_push     (w_rdPush),
    .i_data     (ext_in_data),
    .i_pop      (w_rdPop),
    .o_data     (io_read_data),
    .o_notEmpty (w_rdNotEmpty),
    .o_notFull  (w_rdNotFull)
  );

  io_port_fifo #(
    .WORD_WIDTH  (WORD_WIDTH),
    .DEPTH       (FIFO_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_writeFifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_push     (w_wrPush),
    .i_data     (io_write_data),
    .i_pop      (w_wrPop),
    .o_data     (ext_out_data),
    .o_notEmpty (w_wrNotEmpty),
    .o_notFull  (w_wrNotFull)
  );

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdUnderrun <= 1'b0;
      r_wrOverrun  <= 1'b0;
    end else begin
      if (w_rdUnderrunSet) begin
        r_rdUnderrun <= 1'b1;
      end else if (clear_errors) begin
        r_rdUnderrun <= 1'b0;
      end
      if (w_wrOverrunSet) begin
        r_wrOverrun <= 1'b1;
      end else if (clear_errors) begin
        r_wrOverrun <= 1'b0;
      end
    end
  end

  assign rd_underrun = r_rdUnderrun;
  assign wr_overrun  = r_wrOverrun;

endmodule

// File: tb/tb_io_port_endpoint.sv
// Directed bench for io_port_endpoint: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (fill/drain, overrun,
// steady-state streaming, asynchronous reset mid-stream).
module tb_io_port_endpoint;

  localparam int W = 36;

  logic         clock;
  logic         reset_n;
  logic         io_rden;
  logic [W-1:0] io_read_data;
  logic         io_read_EF;
  logic         io_wren;
  logic [W-1:0] io_write_data;
  logic         io_write_EF;
  logic         ext_in_valid;
  logic         ext_in_ready;
  logic [W-1:0] ext_in_data;
  logic         ext_out_valid;
  logic         ext_out_ready;
  logic [W-1:0] ext_out_data;
  logic         clear_errors;
  logic         rd_underrun;
  logic         wr_overrun;

  int assertCount;
  int failCount;

  typedef struct packed {
    logic         rden;
    logic         wren;
    logic [W-1:0] wdata;
    logic         inValid;
    logic [W-1:0] inData;
    logic         outReady;
    logic         clearErr;
    logic         expReadEF;
    logic [W-1:0] expReadData;
    logic         expWriteEF;
    logic         expInReady;
    logic         expOutValid;
    logic [W-1:0] expOutData;
    logic         expRdUnder;
    logic         expWrOver;
  } vecT;

  vecT vecs [13];

  io_port_endpoint dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .io_rden       (io_rden),
    .io_read_data  (io_read_data),
    .io_read_EF    (io_read_EF),
    .io_wren       (io_wren),
    .io_write_data (io_write_data),
    .io_write_EF   (io_write_EF),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ext_in_data   (ext_in_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_out_data  (ext_out_data),
    .clear_errors  (clear_errors),
    .rd_underrun   (rd_underrun),
    .wr_overrun    (wr_overrun)
  );

  // Free-running 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vecT mkVec(
    input logic rden, input logic wren, input logic [W-1:0] wdata,
    input logic inValid, input logic [W-1:0] inData,
    input logic outReady, input logic clearErr,
    input logic eRdEF, input logic [W-1:0] eRdData, input logic eWrEF,
    input logic eInReady, input logic eOutValid, input logic [W-1:0] eOutData,
    input logic eRdUnder, input logic eWrOver);
    vecT v;
    v.rden = rden; v.wren = wren; v.wdata = wdata;
    v.inValid = inValid; v.inData = inData;
    v.outReady = outReady; v.clearErr = clearErr;
    v.expReadEF = eRdEF; v.expReadData = eRdData; v.expWriteEF = eWrEF;
    v.expInReady = eInReady; v.expOutValid = eOutValid; v.expOutData = eOutData;
    v.expRdUnder = eRdUnder; v.expWrOver = eWrOver;
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idleInputs();
    io_rden = 1'b0; io_wren = 1'b0; io_write_data = '0;
    ext_in_valid = 1'b0; ext_in_data = '0;
    ext_out_ready = 1'b0; clear_errors = 1'b0;
  endtask

  task automatic applyStimulus(input vecT v);
    io_rden = v.rden; io_wren = v.wren; io_write_data = v.wdata;
    ext_in_valid = v.inValid; ext_in_data = v.inData;
    ext_out_ready = v.outReady; clear_errors = v.clearErr;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int idx, input vecT v);
    string p;
    p = $sformatf("vec%0d", idx);
    checkOutput({p, " io_read_EF"},    64'(io_read_EF),    64'(v.expReadEF));
    checkOutput({p, " io_read_data"},  64'(io_read_data),  64'(v.expReadData));
    checkOutput({p, " io_write_EF"},   64'(io_write_EF),   64'(v.expWriteEF));
    checkOutput({p, " ext_in_ready"},  64'(ext_in_ready),  64'(v.expInReady));
    checkOutput({p, " ext_out_valid"}, 64'(ext_out_valid), 64'(v.expOutValid));
    checkOutput({p, " ext_out_data"},  64'(ext_out_data),  64'(v.expOutData));
    checkOutput({p, " rd_underrun"},   64'(rd_underrun),   64'(v.expRdUnder));
    checkOutput({p, " wr_overrun"},    64'(wr_overrun),    64'(v.expWrOver));
  endtask

  task automatic checkResetValues(input string p);
    checkOutput({p, " io_read_EF"},    64'(io_read_EF),    64'(0));
    checkOutput({p, " io_read_data"},  64'(io_read_data),  64'(0));
    checkOutput({p, " io_write_EF"},   64'(io_write_EF),   64'(1));
    checkOutput({p, " ext_in_ready"},  64'(ext_in_ready),  64'(1));
    checkOutput({p, " ext_out_valid"}, 64'(ext_out_valid), 64'(0));
    checkOutput({p, " ext_out_data"},  64'(ext_out_data),  64'(0));
    checkOutput({p, " rd_underrun"},   64'(rd_underrun),   64'(0));
    checkOutput({p, " wr_overrun"},    64'(wr_overrun),    64'(0));
  endtask

  // Main test sequence
  initial begin
    assertCount = 0;
    failCount   = 0;

    // rden wren wdata inV inData outR clr | rEF rData wEF inR outV outData rdU wrO
    vecs[0]  = mkVec(0,0,36'h0,    0,36'h0,         0,0, 0,36'h0,         1,1,0,36'h0,     0,0);
    vecs[1]  = mkVec(0,0,36'h0,    1,36'h123456789, 0,0, 1,36'h123456789, 1,1,0,36'h0,     0,0);
    vecs[2]  = mkVec(1,0,36'h0,    0,36'h0,         0,0, 0,36'h123456789, 1,1,0,36'h0,     0,0);
    vecs[3]  = mkVec(0,1,36'hABCDE,0,36'h0,         0,0, 0,36'h123456789, 1,1,1,36'hABCDE, 0,0);
    vecs[4]  = mkVec(0,1,36'h11111,0,36'h0,         1,0, 0,36'h123456789, 1,1,1,36'h11111, 0,0);
    vecs[5]  = mkVec(0,0,36'h0,    0,36'h0,         1,0, 0,36'h123456789, 1,1,0,36'h11111, 0,0);
    vecs[6]  = mkVec(1,0,36'h0,    0,36'h0,         0,0, 0,36'h123456789, 1,1,0,36'h11111, 1,0);
    vecs[7]  = mkVec(0,0,36'h0,    0,36'h0,         0,1, 0,36'h123456789, 1,1,0,36'h11111, 0,0);
    vecs[8]  = mkVec(1,0,36'h0,    0,36'h0,         0,1, 0,36'h123456789, 1,1,0,36'h11111, 1,0);
    vecs[9]  = mkVec(0,0,36'h0,    0,36'h0,         0,1, 0,36'h123456789, 1,1,0,36'h11111, 0,0);
    vecs[10] = mkVec(1,0,36'h0,    1,36'h5,         0,0, 1,36'h5,         1,1,0,36'h11111, 1,0);
    vecs[11] = mkVec(1,0,36'h0,    1,36'h6,         0,0, 1,36'h6,         1,1,0,36'h11111, 1,0);
    vecs[12] = mkVec(1,0,36'h0,    0,36'h0,         0,1, 0,36'h6,         1,1,0,36'h11111, 0,0);

    idleInputs();
    reset_n = 1'b0;
    repeat (2) tick();
    checkResetValues("reset");
    reset_n = 1'b1;

    // Single-cycle vectors
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkVector(i, vecs[i]);
    end
    idleInputs();

    // Fill the read FIFO with 1..8, try a 9th push while full, then pop in order
    for (int i = 1; i <= 9; i++) begin
      ext_in_valid = 1'b1;
      ext_in_data  = (i == 9) ? 36'd99 : W'(i);
      tick();
    end
    idleInputs();
    checkOutput("full ext_in_ready", 64'(ext_in_ready), 64'(0));
    checkOutput("full io_read_EF",   64'(io_read_EF),   64'(1));
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("pop%0d io_read_data", i), 64'(io_read_data), 64'(i));
      io_rden = 1'b1;
      tick();
    end
    io_rden = 1'b0;
    checkOutput("drained io_read_EF",   64'(io_read_EF),   64'(0));
    checkOutput("drained ext_in_ready", 64'(ext_in_ready), 64'(1));
    checkOutput("pre-underrun flag",    64'(rd_underrun),  64'(0));
    io_rden = 1'b1;
    tick();
    io_rden = 1'b0;
    checkOutput("9th pop rd_underrun", 64'(rd_underrun), 64'(1));

    // Write FIFO overrun: 9 writes with the consumer stalled
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      io_wren = 1'b1;
      io_write_data = W'(i);
      tick();
    end
    io_wren = 1'b0;
    checkOutput("ovr io_write_EF",   64'(io_write_EF),   64'(0));
    checkOutput("ovr wr_overrun",    64'(wr_overrun),    64'(1));
    checkOutput("ovr ext_out_valid", 64'(ext_out_valid), 64'(1));
    checkOutput("ovr ext_out_data",  64'(ext_out_data),  64'(1));
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    checkOutput("ovr cleared", 64'(wr_overrun), 64'(0));
    // Write at full together with a consumer pop: the write is still dropped
    io_wren = 1'b1;
    io_write_data = 36'h77;
    ext_out_ready = 1'b1;
    tick();
    io_wren = 1'b0;
    checkOutput("full+pop wr_overrun",   64'(wr_overrun),   64'(1));
    checkOutput("full+pop io_write_EF",  64'(io_write_EF),  64'(1));
    for (int i = 2; i <= 8; i++) begin
      checkOutput($sformatf("drain%0d ext_out_data", i), 64'(ext_out_data), 64'(i));
      checkOutput($sformatf("drain%0d ext_out_valid", i), 64'(ext_out_valid), 64'(1));
      tick();
    end
    ext_out_ready = 1'b0;
    checkOutput("drained ext_out_valid", 64'(ext_out_valid), 64'(0));
    checkOutput("drained ext_out_data",  64'(ext_out_data),  64'(8));

    // Steady streaming at occupancy 4 on both FIFOs
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ext_in_valid = 1'b1; ext_in_data = W'(10 + k);
      io_wren = 1'b1;      io_write_data = W'(20 + k);
      tick();
    end
    idleInputs();
    checkOutput("prefill io_read_data", 64'(io_read_data), 64'(10));
    checkOutput("prefill ext_out_data", 64'(ext_out_data), 64'(20));
    for (int k = 0; k < 20; k++) begin
      ext_in_valid = 1'b1; ext_in_data = W'(14 + k); io_rden = 1'b1;
      io_wren = 1'b1;      io_write_data = W'(24 + k); ext_out_ready = 1'b1;
      tick();
      checkOutput($sformatf("stream%0d io_read_data", k), 64'(io_read_data), 64'(11 + k));
      checkOutput($sformatf("stream%0d ext_out_data", k), 64'(ext_out_data), 64'(21 + k));
    end
    idleInputs();
    checkOutput("stream io_read_EF",    64'(io_read_EF),    64'(1));
    checkOutput("stream ext_in_ready",  64'(ext_in_ready),  64'(1));
    checkOutput("stream io_write_EF",   64'(io_write_EF),   64'(1));
    checkOutput("stream ext_out_valid", 64'(ext_out_valid), 64'(1));
    checkOutput("stream rd_underrun",   64'(rd_underrun),   64'(0));
    checkOutput("stream wr_overrun",    64'(wr_overrun),    64'(0));
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("tail%0d io_read_data", k), 64'(io_read_data), 64'(30 + k));
      io_rden = 1'b1;
      tick();
    end
    io_rden = 1'b0;
    checkOutput("tail io_read_EF", 64'(io_read_EF), 64'(0));
    io_rden = 1'b1;
    clear_errors = 1'b1;
    tick();
    idleInputs();
    checkOutput("set beats clear", 64'(rd_underrun), 64'(1));
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    checkOutput("clear rd_underrun", 64'(rd_underrun), 64'(0));

    // Asynchronous reset with both FIFOs at occupancy 5
    for (int k = 0; k < 5; k++) begin
      ext_in_valid = 1'b1; ext_in_data = W'(50 + k);
      io_wren = (k == 0); io_write_data = 36'd44;
      tick();
    end
    idleInputs();
    checkOutput("pre-reset io_read_data", 64'(io_read_data), 64'(50));
    checkOutput("pre-reset ext_out_data", 64'(ext_out_data), 64'(40));
    #2 reset_n = 1'b0;
    #1 checkResetValues("async");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkResetValues("post-reset");
    ext_in_valid = 1'b1; ext_in_data = 36'h55;
    io_wren = 1'b1;      io_write_data = 36'h66;
    tick();
    idleInputs();
    checkOutput("fresh io_read_data", 64'(io_read_data), 64'h55);
    checkOutput("fresh io_read_EF",   64'(io_read_EF),   64'(1));
    checkOutput("fresh ext_out_data", 64'(ext_out_data), 64'h66);
    io_rden = 1'b1;
    ext_out_ready = 1'b1;
    tick();
    idleInputs();
    checkOutput("fresh single io_read_EF",    64'(io_read_EF),    64'(0));
    checkOutput("fresh single ext_out_valid", 64'(ext_out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
